// File: rtl/seq_divider_pkg.sv
// Shared ALU definitions: divider state encoding and divide-by-zero result fill.
package seq_divider_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Every quotient bit is set on divide-by-zero (all-ones quotient).
  localparam logic DBZ_QUOTIENT_BIT = 1'b1;

endpackage

// File: rtl/nbit_adder.sv
// Ripple-carry adder built from a chain of full-adder bit cells.
module nbit_adder #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < N; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry[N];

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one trial subtraction per clock, WIDTH iterations.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dq_q;
  logic [WIDTH-1:0] div_q;
  // Partial remainder stays below the divisor, so its top (WIDTH+1) bit is always zero.
  logic [WIDTH-1:0] part_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] part_next;
  logic [WIDTH-1:0] dq_next;
  logic             adder_cout_unused;

  assign p_shift = {part_q, dq_q[WIDTH-1]};

  // Subtraction as A + ~B + 1 on the shared adder chain.
  nbit_adder #(
    .N(WIDTH + 1)
  ) u_trial_sub (
    .a   (p_shift),
    .b   (~{1'b0, div_q}),
    .cin (1'b1),
    .sum (trial),
    .cout(adder_cout_unused)
  );

  always_comb begin
    q_bit     = ~trial[WIDTH];
    part_next = q_bit ? trial[WIDTH-1:0] : p_shift[WIDTH-1:0];
    dq_next   = {dq_q[WIDTH-2:0], q_bit};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dq_q    <= '0;
      div_q   <= '0;
      part_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            if (Divisor == '0) begin
              state_q <= ST_DONE;
              quo_q   <= {WIDTH{DBZ_QUOTIENT_BIT}};
              rem_q   <= Dividend;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              dq_q    <= Dividend;
              div_q   <= Divisor;
              part_q  <= '0;
              cnt_q   <= CNT_LAST;
            end
          end
        end
        ST_RUN: begin
          part_q <= part_next;
          dq_q   <= dq_next;
          if (cnt_q == '0) begin
            state_q <= ST_DONE;
            quo_q   <= dq_next;
            rem_q   <= part_next;
            dbz_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Quotient  = quo_q;
  assign Remainder = rem_q;
  assign DivByZero = dbz_q;
  assign Busy      = (state_q == ST_RUN);
  assign Done      = (state_q == ST_DONE);

endmodule
